// File: rtl/overlap_add_synth.sv
// 50%-overlap-add synthesis stage: rebuilds a continuous sample stream from consecutive IFFT frames.
// First half of each frame is summed with the stored tail of the previous frame; second half becomes the new tail.
module overlap_add_synth #(
  parameter int unsigned FFT_SIZE = 1024,
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_in,
  input  logic signed [IN_W-1:0]  ifft_in_re,
  input  logic                    flush,
  output logic                    enable_out,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy_flush
);

  localparam int unsigned HOP   = FFT_SIZE / 2;
  localparam int unsigned IDX_W = $clog2(FFT_SIZE);
  localparam int unsigned HOP_W = IDX_W - 1;
  localparam int unsigned SUM_W = IN_W + 1;
  localparam int unsigned EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [HOP_W-1:0]          fcnt_q, fcnt_d;
  logic                      first_q, first_d;
  logic                      enable_out_q, enable_out_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      busy_flush_q, busy_flush_d;

  logic signed [IN_W-1:0]    tail_mem [HOP];
  logic [HOP_W-1:0]          rd_addr_c;
  logic signed [IN_W-1:0]    tail_rd_c;
  logic signed [IN_W-1:0]    addend_c;
  logic signed [SUM_W-1:0]   sum_c;
  logic                      tail_we_c;
  logic [HOP_W-1:0]          wr_addr_c;

  // Arithmetic shift then clamp into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_shift(input logic signed [SUM_W-1:0] val);
    logic signed [SUM_W-1:0] sh;
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    sh = val >>> SHIFT;
    x  = EXT_W'(sh);
    hi = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
    lo = ~hi;
    if (x > hi) begin
      sat_shift = hi[OUT_W-1:0];
    end else if (x < lo) begin
      sat_shift = lo[OUT_W-1:0];
    end else begin
      sat_shift = x[OUT_W-1:0];
    end
  endfunction

  // Tail read port: overlap slot while running, drain pointer while flushing.
  always_comb begin
    rd_addr_c = (state_q == ST_FLUSH) ? fcnt_q : idx_q[HOP_W-1:0];
    tail_rd_c = tail_mem[rd_addr_c];
    addend_c  = first_q ? '0 : tail_rd_c;
    sum_c     = SUM_W'(ifft_in_re) + SUM_W'(addend_c);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fcnt_d       = fcnt_q;
    first_d      = first_q;
    enable_out_d = 1'b0;
    out_data_d   = out_data_q;
    busy_flush_d = 1'b0;
    tail_we_c    = 1'b0;
    wr_addr_c    = idx_q[HOP_W-1:0];

    case (state_q)
      ST_RUN: begin
        if (busy_flush_q) begin
          // last drained sample is on the output; inputs this cycle are dropped
        end else if (flush && !enable_in && (idx_q == '0) && !first_q) begin
          state_d      = ST_FLUSH;
          fcnt_d       = HOP_W'(1);
          enable_out_d = 1'b1;
          busy_flush_d = 1'b1;
          out_data_d   = sat_shift(SUM_W'(tail_rd_c));
        end else if (enable_in) begin
          idx_d = idx_q + 1'b1;
          if (!idx_q[IDX_W-1]) begin
            enable_out_d = 1'b1;
            out_data_d   = sat_shift(sum_c);
          end else begin
            tail_we_c = 1'b1;
            if (idx_q == IDX_W'(FFT_SIZE - 1)) begin
              first_d = 1'b0;
            end
          end
        end
      end
      ST_FLUSH: begin
        enable_out_d = 1'b1;
        busy_flush_d = 1'b1;
        out_data_d   = sat_shift(SUM_W'(tail_rd_c));
        fcnt_d       = fcnt_q + 1'b1;
        if (fcnt_q == HOP_W'(HOP - 1)) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      fcnt_q       <= '0;
      first_q      <= 1'b1;
      enable_out_q <= 1'b0;
      out_data_q   <= '0;
      busy_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      first_q      <= first_d;
      enable_out_q <= enable_out_d;
      out_data_q   <= out_data_d;
      busy_flush_q <= busy_flush_d;
    end
  end

  // Tail storage is never reset; first_q masks stale contents.
  always_ff @(posedge clk) begin
    if (tail_we_c) begin
      tail_mem[wr_addr_c] <= ifft_in_re;
    end
  end

  assign enable_out = enable_out_q;
  assign out_data   = out_data_q;
  assign busy_flush = busy_flush_q;

endmodule
